// File: rtl/etapa_fetch.sv
// etapa_fetch: instruction-fetch stage.
// Owns the program counter and keeps at most one read in flight to instruction memory.
// Fetched words are buffered in a 2-entry queue that the decode stage drains
// through a valid/stall handshake.
// A redirect from execute flushes the queue and discards any response still in flight.

module etapa_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4
);

  // S_WAIT keeps the pending response; S_DROP throws it away (it belongs to a flushed path)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_reqPc4;
  logic [31:0] r_fifoPc4   [2];
  logic [31:0] r_fifoInstr [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic [2:0]  w_occupancy;
  logic        w_room;
  logic        w_issue;
  logic        w_tail;

  // A redirect kills both the consumer side and the producer side of the queue in its cycle
  assign w_pop  = (r_count != 2'd0) && !stall && !redirect;
  assign w_push = (r_state == S_WAIT) && imem_valid && !redirect;

  // Occupancy after this cycle's pop/push; a new request is only allowed if its
  // eventual response is guaranteed a slot
  assign w_occupancy = {1'b0, r_count} + {2'b00, w_push} - {2'b00, w_pop};
  assign w_room      = (w_occupancy < 3'd2);

  // A request can go out from IDLE, or back-to-back in the cycle the previous
  // response arrives, which is what gives one instruction per cycle with 1-cycle memory
  assign w_issue = !rst && !redirect && w_room &&
                   ((r_state == S_IDLE) || ((r_state == S_WAIT) && imem_valid));

  assign imem_req  = w_issue;
  assign imem_addr = w_issue ? r_pc : 32'h0000_0000;

  // The write slot sits just past the live entries; with a 2-deep queue that is head xor count[0]
  assign w_tail = r_head ^ r_count[0];

  assign if_valid = (r_count != 2'd0);
  assign if_instr = if_valid ? r_fifoInstr[r_head] : 32'h0000_0000;
  assign if_pc4   = if_valid ? r_fifoPc4[r_head]   : 32'h0000_0000;

  // Request FSM and program counter; redirect overrides everything except reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_reqPc4 <= 32'h0000_0000;
    end else if (redirect) begin
      r_pc <= redirect_pc & 32'hFFFF_FFFC;
      if (imem_valid) begin
        r_state <= S_IDLE;
      end else if (r_state == S_WAIT) begin
        r_state <= S_DROP;
      end
    end else begin
      if (w_issue) begin
        r_pc     <= r_pc + 32'd4;
        r_reqPc4 <= r_pc + 32'd4;
        r_state  <= S_WAIT;
      end else begin
        case (r_state)
          S_WAIT:  if (imem_valid) r_state <= S_IDLE;
          S_DROP:  if (imem_valid) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Queue storage: a kept response lands in the tail slot together with its pc+4
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifoPc4[i]   <= 32'h0000_0000;
        r_fifoInstr[i] <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_fifoPc4[w_tail]   <= r_reqPc4;
      r_fifoInstr[w_tail] <= imem_rdata;
    end
  end

  // Queue bookkeeping: occupancy and head pointer, emptied by reset or redirect
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      r_count <= w_occupancy[1:0];
      if (w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

endmodule
